// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and the slice width.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
//   start/sub/cin/a/b : request, driven by master
//   busy/done/sum/cout/ovf : status and result, driven by slave
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
//   a, b : nibble operands    cin : carry in
//   s    : nibble sum         c3  : carry into bit 3    cout : carry out of bit 3
module nibble_serial_adder_ctrl_cla4_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic                c1;
    logic                c2;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry expanded directly from generate/propagate terms, no ripple.
    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit lookahead slice reused over
// WIDTH/4 cycles, LSB nibble first, with a start/busy/done handshake.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of nibble_serial_adder_ctrl_if (request in, result out)
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    import nibble_serial_adder_ctrl_pkg::*;

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                carry_q, carry_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c3;
    logic                slice_cout;

    // Select the operand nibbles addressed by the counter.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_serial_adder_ctrl_cla4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (slice_s),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // Subtract as a + ~b + 1; cin is ignored for sub.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
                    end
                end
                carry_d = slice_cout;
                if (cnt_q == LAST_NIB) begin
                    // Signed overflow from the top slice's last two carries.
                    cout_d  = slice_cout;
                    ovf_d   = slice_c3 ^ slice_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ADD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
    localparam int unsigned W = 16;

    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic; overflow when same-sign operands give other-sign result.
    task automatic model(input logic s, input logic c, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         ci;
        yy   = s ? ~y : y;
        ci   = s ? 1'b1 : c;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
        rs   = full[W-1:0];
        rc   = full[W];
        ro   = (x[W-1] == yy[W-1]) && (rs[W-1] != x[W-1]);
    endtask

    // Present a request (called just after a falling edge).
    task automatic issue(input logic s, input logic c, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.sub   = s;
        bus.cin   = c;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
    endtask

    task automatic scramble();
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    // Walk the ADD cycles and the DONE cycle after an accept, checking the handshake and result.
    task automatic follow(input bit hold_start, input bit poke);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("busy_in_add", 32'(bus.busy), 32'd1);
            chk("done_in_add", 32'(bus.done), 32'd0);
            if (hold_start) bus.start = 1'b1;
            else            bus.start = poke && (i == 2);
            scramble();
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        chk("sum", 32'(bus.sum), 32'(exp_sum));
        chk("cout", 32'(bus.cout), 32'(exp_cout));
        chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] x, y;
        logic         s, c;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; odd entries also pulse start during ADD.
        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].sub, vecs[v].cin, vecs[v].a, vecs[v].b);
            exp_sum  = vecs[v].e_sum;
            exp_cout = vecs[v].e_cout;
            exp_ovf  = vecs[v].e_ovf;
            follow(1'b0, (v % 2) == 1);
            @(negedge clk);
            chk("idle_after_done", 32'(bus.done), 32'd0);
        end

        // Hold: results remain stable with start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_sum",  32'(bus.sum),  32'(exp_sum));
            chk("hold_cout", 32'(bus.cout), 32'(exp_cout));
            chk("hold_ovf",  32'(bus.ovf),  32'(exp_ovf));
            chk("hold_busy", 32'(bus.busy), 32'd0);
            chk("hold_done", 32'(bus.done), 32'd0);
        end

        // Randomized operations against the reference model.
        for (int r = 0; r < 24; r++) begin
            s = 1'($urandom);
            c = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            issue(s, c, x, y);
            model(s, c, x, y, exp_sum, exp_cout, exp_ovf);
            follow(1'b0, (r % 3) == 0);
            if (r % 2 == 1) @(negedge clk);
        end

        // start held high: a new op is taken only in each DONE cycle.
        s = 1'($urandom); c = 1'($urandom); x = W'($urandom); y = W'($urandom);
        issue(s, c, x, y);
        model(s, c, x, y, exp_sum, exp_cout, exp_ovf);
        for (int n = 0; n < 4; n++) begin
            follow(1'b1, 1'b0);
            s = 1'($urandom); c = 1'($urandom); x = W'($urandom); y = W'($urandom);
            issue(s, c, x, y);
            model(s, c, x, y, exp_sum, exp_cout, exp_ovf);
        end
        follow(1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        issue(1'b0, 1'b0, 16'hABCD, 16'h1111);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_sum",  32'(bus.sum),  32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        chk("mid_rst_ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(bus.done), 32'd0);
            chk("no_busy_after_rst", 32'(bus.busy), 32'd0);
        end
        issue(1'b0, 1'b0, 16'h0001, 16'h0001);
        exp_sum  = 16'h0002;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        follow(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by reusing one 4-bit carry-lookahead slice over WIDTH/4 cycles, least-significant nibble first.
- Holds the inter-nibble carry in a register and supports add and subtract.
- Presents a start/busy/done handshake and holds the result until the next start is accepted.
- Sits between the control path and the 4-bit lookahead adder datapath, so wide additions need no wide carry chain.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES (localparam), WIDTH/4, number of ADD cycles per operation.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on clk.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1, cin ignored); latched on accept.
- cin  input  1  carry-in for add; latched on accept.
- a  input  WIDTH  operand A; latched on accept.
- b  input  WIDTH  operand B; latched on accept.
- busy  output  1  high while an operation is in progress (ADD state).
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH  result; holds its value until the next accept.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any state): state=IDLE, nibble counter=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, busy=0, done=0.
- FSM states: IDLE, ADD, DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE. On accept:
  - latch a; latch b (bitwise inverted if sub=1); carry reg = sub ? 1 : cin.
  - counter=0; clear sum; state -> ADD.
- start while in ADD is ignored and does not queue.
- ADD, each cycle i (0..NIBBLES-1):
  - The slice adds a[4i+3:4i], b'[4i+3:4i] and the carry reg.
  - Its 4-bit sum is written to sum[4i+3:4i], its carry-out to the carry reg, and counter increments.
  - On the i=NIBBLES-1 edge: cout = slice carry-out; ovf = slice carry into bit 3 XOR slice carry-out; state -> DONE.
- DONE lasts one cycle: done=1, busy=0. Then state -> IDLE, or -> ADD if start=1 (back-to-back accept).
- Latency: start sampled at edge k gives busy high in cycles k+1 .. k+NIBBLES and done high in cycle k+NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- busy is a registered state decode (ADD); done is a registered state decode (DONE); there are no combinational paths from inputs to outputs.
- sum, cout and ovf are stable in DONE and IDLE.
- sum bits not yet written read as 0 during ADD; consumers use them only when done=1 or in IDLE.
- Counter: width clog2(NIBBLES), minimum 1 bit; never exceeds NIBBLES-1.
- WIDTH=4 case: a single ADD cycle.
- Changes on a/b/cin/sub after accept do not affect the operation in flight.
- Reset mid-operation aborts immediately; no done pulse is produced.

Decomposition:
- Shared package/header adder_defs:
  - state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module, cla4_slice (combinational), built on the team's 4-bit lookahead carry logic.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], c3 (carry into bit 3), cout.
  - Internals: p=a^b, g=a&b, lookahead carries, s=p^{carries,cin}.
- The controller owns the FSM, counter, operand/carry registers and result assembly.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0, start at edge k -> busy high in cycles k+1..k+4; done=1 only at k+5; sum=0x5555, cout=0, ovf=0.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - start held high continuously with changing operands -> a new operation is accepted only at each DONE cycle (done pulses every 5 cycles);
  - start pulses during ADD have no effect;
  - operand changes after accept do not alter the result.
- Reset mid-operation: assert rst asynchronously between edges during ADD cycle 2 -> all outputs 0 immediately, no done pulse. After release, start with 0x0001+0x0001 -> sum=0x0002 after 5 cycles.
- Hold: after done, keep start=0 for 10 cycles -> sum, cout and ovf unchanged; busy=0, done=0.
